// File: rtl/cache_pkg.sv
// Shared cache-subsystem definitions: geometry constants, refill FSM states and
// the critical-word-first wrap helper.
package cache_pkg;

    localparam int unsigned ADR_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned LINE_WIDTH     = WORDS_PER_LINE * DATA_WIDTH;
    localparam int unsigned OFFSET_LSB     = 2;
    localparam int unsigned LINE_LSB       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWb,
        StRd,
        StResp
    } refill_state_e;

    // Word slot visited at step k of a wrap burst starting at base; wraps 3 -> 0.
    function automatic logic [1:0] wrap_idx(input logic [1:0] base, input logic [1:0] k);
        return base + k;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Refill assembly buffer: holds the incoming line, the burst word counter and the
// critical-word offset, and produces the slot the current read lands in.
module line_buffer #(
    parameter int unsigned DATA_WIDTH = cache_pkg::DATA_WIDTH,
    parameter int unsigned WORDS      = cache_pkg::WORDS_PER_LINE
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [1:0]                    crit_i,
    input  logic                          adv_i,
    input  logic                          wr_i,
    input  logic [DATA_WIDTH-1:0]         wr_dat_i,
    output logic [1:0]                    cnt_o,
    output logic [1:0]                    crit_o,
    output logic [1:0]                    slot_o,
    output logic [WORDS*DATA_WIDTH-1:0]   line_o
);
    import cache_pkg::*;

    logic [1:0]                       cnt_q;
    logic [1:0]                       crit_q;
    logic [WORDS-1:0][DATA_WIDTH-1:0] line_q;

    // Counter restarts per request; it advances on every accepted memory word and
    // wraps naturally from the writeback burst into the read burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 2'd0;
            crit_q <= 2'd0;
        end else if (start_i) begin
            cnt_q  <= 2'd0;
            crit_q <= crit_i;
        end else if (adv_i) begin
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    // Line storage is only written by read data, so the previous line stays visible
    // until new words arrive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_q <= '0;
        end else if (wr_i) begin
            line_q[slot_o] <= wr_dat_i;
        end
    end

    assign cnt_o  = cnt_q;
    assign crit_o = crit_q;
    assign slot_o = wrap_idx(crit_q, cnt_q);
    assign line_o = line_q;

endmodule

// File: rtl/line_refill_ctrl.sv
// Memory-side refill controller: optional dirty-victim writeback followed by a
// critical-word-first line read, with early critical word and full-line handback.
module line_refill_ctrl #(
    parameter int unsigned ADR_WIDTH      = cache_pkg::ADR_WIDTH,
    parameter int unsigned DATA_WIDTH     = cache_pkg::DATA_WIDTH,
    parameter int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cache_req_i,
    input  logic [ADR_WIDTH-1:0]                 cache_adr_i,
    input  logic                                 victim_vld_i,
    input  logic [ADR_WIDTH-1:0]                 victim_adr_i,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] victim_dat_i,
    output logic                                 cache_busy_o,
    output logic                                 cache_crit_vld_o,
    output logic [DATA_WIDTH-1:0]                cache_crit_dat_o,
    output logic                                 cache_ack_o,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] cache_line_o,
    output logic                                 mem_req_o,
    output logic                                 mem_we_o,
    output logic [ADR_WIDTH-1:0]                 mem_adr_o,
    output logic [DATA_WIDTH-1:0]                mem_dat_o,
    input  logic                                 mem_ack_i,
    input  logic [DATA_WIDTH-1:0]                mem_dat_i
);
    import cache_pkg::*;

    localparam int unsigned TagW = ADR_WIDTH - LINE_LSB;

    refill_state_e                             state_q;
    logic [TagW-1:0]                           line_adr_q;
    logic [TagW-1:0]                           victim_line_q;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] victim_dat_q;

    logic                  busy_q;
    logic                  crit_vld_q;
    logic [DATA_WIDTH-1:0] crit_dat_q;
    logic                  ack_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADR_WIDTH-1:0]  mem_adr_q;
    logic [DATA_WIDTH-1:0] mem_dat_q;

    logic       buf_start;
    logic       buf_adv;
    logic       buf_wr;
    logic [1:0] cnt;
    logic [1:0] crit;
    logic [1:0] slot;
    logic [1:0] nxt_cnt;
    logic [1:0] nxt_rd_idx;
    logic       last_word;
    logic       unused_adr_bits;

    // Buffer strobes decoded from the current state and memory handshake.
    always_comb begin
        buf_start  = 1'b0;
        buf_adv    = 1'b0;
        buf_wr     = 1'b0;
        nxt_cnt    = cnt + 2'd1;
        nxt_rd_idx = wrap_idx(crit, nxt_cnt);
        last_word  = (cnt == 2'd3);
        unique case (state_q)
            StIdle: buf_start = cache_req_i;
            StWb:   buf_adv   = mem_ack_i;
            StRd: begin
                buf_adv = mem_ack_i;
                buf_wr  = mem_ack_i;
            end
            default: ;
        endcase
    end

    line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (WORDS_PER_LINE)
    ) u_line_buffer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .start_i  (buf_start),
        .crit_i   (cache_adr_i[LINE_LSB-1:OFFSET_LSB]),
        .adv_i    (buf_adv),
        .wr_i     (buf_wr),
        .wr_dat_i (mem_dat_i),
        .cnt_o    (cnt),
        .crit_o   (crit),
        .slot_o   (slot),
        .line_o   (cache_line_o)
    );

    // Refill FSM; every output is registered here and the memory request fields
    // only change on the edge that samples mem_ack_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            line_adr_q    <= '0;
            victim_line_q <= '0;
            victim_dat_q  <= '0;
            busy_q        <= 1'b0;
            crit_vld_q    <= 1'b0;
            crit_dat_q    <= '0;
            ack_q         <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_adr_q     <= '0;
            mem_dat_q     <= '0;
        end else begin
            crit_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cache_req_i) begin
                        line_adr_q    <= cache_adr_i[ADR_WIDTH-1:LINE_LSB];
                        victim_line_q <= victim_adr_i[ADR_WIDTH-1:LINE_LSB];
                        victim_dat_q  <= victim_dat_i;
                        busy_q        <= 1'b1;
                        mem_req_q     <= 1'b1;
                        if (victim_vld_i) begin
                            state_q   <= StWb;
                            mem_we_q  <= 1'b1;
                            mem_adr_q <= {victim_adr_i[ADR_WIDTH-1:LINE_LSB], 2'b00, 2'b00};
                            mem_dat_q <= victim_dat_i[DATA_WIDTH-1:0];
                        end else begin
                            state_q   <= StRd;
                            mem_we_q  <= 1'b0;
                            mem_adr_q <= {cache_adr_i[ADR_WIDTH-1:OFFSET_LSB], 2'b00};
                            mem_dat_q <= '0;
                        end
                    end
                end
                StWb: begin
                    if (mem_ack_i) begin
                        if (last_word) begin
                            // Writeback done; open the read burst at the critical word.
                            state_q   <= StRd;
                            mem_we_q  <= 1'b0;
                            mem_adr_q <= {line_adr_q, crit, 2'b00};
                            mem_dat_q <= '0;
                        end else begin
                            mem_adr_q <= {victim_line_q, nxt_cnt, 2'b00};
                            mem_dat_q <= victim_dat_q[nxt_cnt];
                        end
                    end
                end
                StRd: begin
                    if (mem_ack_i) begin
                        if (cnt == 2'd0) begin
                            crit_vld_q <= 1'b1;
                            crit_dat_q <= mem_dat_i;
                        end
                        if (last_word) begin
                            state_q   <= StResp;
                            mem_req_q <= 1'b0;
                            ack_q     <= 1'b1;
                        end else begin
                            mem_adr_q <= {line_adr_q, nxt_rd_idx, 2'b00};
                        end
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cache_busy_o     = busy_q;
    assign cache_crit_vld_o = crit_vld_q;
    assign cache_crit_dat_o = crit_dat_q;
    assign cache_ack_o      = ack_q;
    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_adr_o        = mem_adr_q;
    assign mem_dat_o        = mem_dat_q;

    // Byte offsets and the victim offset field carry no information here.
    assign unused_adr_bits = ^{cache_adr_i[OFFSET_LSB-1:0], victim_adr_i[LINE_LSB-1:0], slot};

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Directed bench for line_refill_ctrl: memory transactions are predicted into a
// scoreboard queue when a request is issued and popped as the DUT presents them.
module tb_line_refill_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic         clk;
    logic         rst;
    logic         cache_req_i;
    logic [31:0]  cache_adr_i;
    logic         victim_vld_i;
    logic [31:0]  victim_adr_i;
    logic [127:0] victim_dat_i;
    logic         cache_busy_o;
    logic         cache_crit_vld_o;
    logic [31:0]  cache_crit_dat_o;
    logic         cache_ack_o;
    logic [127:0] cache_line_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_adr_o;
    logic [31:0]  mem_dat_o;
    logic         mem_ack_i;
    logic [31:0]  mem_dat_i;
    logic [31:0]  rd_base;

    int   n_cmp = 0;
    int   n_bad = 0;
    txn_t exp_q[$];

    line_refill_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cache_req_i      (cache_req_i),
        .cache_adr_i      (cache_adr_i),
        .victim_vld_i     (victim_vld_i),
        .victim_adr_i     (victim_adr_i),
        .victim_dat_i     (victim_dat_i),
        .cache_busy_o     (cache_busy_o),
        .cache_crit_vld_o (cache_crit_vld_o),
        .cache_crit_dat_o (cache_crit_dat_o),
        .cache_ack_o      (cache_ack_o),
        .cache_line_o     (cache_line_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_adr_o        (mem_adr_o),
        .mem_dat_o        (mem_dat_o),
        .mem_ack_i        (mem_ack_i),
        .mem_dat_i        (mem_dat_i)
    );

    // Memory model: read data is rd_base plus the word index being addressed.
    assign mem_dat_i = rd_base + {30'd0, mem_adr_o[3:2]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk_line(input logic [31:0] b);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = b + 32'(k);
        return l;
    endfunction

    function automatic logic [255:0] all_outs();
        return 256'({cache_busy_o, cache_crit_vld_o, cache_crit_dat_o, cache_ack_o,
                     cache_line_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o});
    endfunction

    // Runs one miss from the idle cycle in which the request is driven (cycle 0)
    // to the ack cycle, stalling read number stall_k for stall_len cycles.
    task automatic do_miss(input logic [31:0] adr, input logic vv, input logic [31:0] vadr,
                           input logic [127:0] vdat, input int stall_k, input int stall_len);
        txn_t        t;
        int          wb_n;
        int          base;
        int          crit_c;
        int          ack_c;
        int          done;
        int          stall_left;
        logic [1:0]  crit;
        logic [1:0]  idx;
        logic [31:0] exp_crit;
        exp_q.delete();
        crit = adr[3:2];
        wb_n = vv ? 4 : 0;
        if (vv) begin
            for (int k = 0; k < 4; k++) begin
                t.we  = 1'b1;
                t.adr = {vadr[31:4], 2'(k), 2'b00};
                t.dat = vdat[32*k +: 32];
                exp_q.push_back(t);
            end
        end
        for (int k = 0; k < 4; k++) begin
            idx   = crit + 2'(k);
            t.we  = 1'b0;
            t.adr = {adr[31:4], idx, 2'b00};
            t.dat = 32'd0;
            exp_q.push_back(t);
        end
        exp_crit     = rd_base + 32'(crit);
        base         = vv ? 5 : 1;
        crit_c       = base + 1 + ((stall_k == 0) ? stall_len : 0);
        ack_c        = base + 4 + ((stall_k >= 0) ? stall_len : 0);
        done         = 0;
        stall_left   = stall_len;
        cache_req_i  = 1'b1;
        cache_adr_i  = adr;
        victim_vld_i = vv;
        victim_adr_i = vadr;
        victim_dat_i = vdat;
        for (int c = 1; c <= ack_c; c++) begin
            tick();
            mem_ack_i = 1'b1;
            if (done >= wb_n && (done - wb_n) == stall_k && stall_left > 0) begin
                mem_ack_i = 1'b0;
                stall_left--;
            end
            check("busy", 256'(cache_busy_o), 256'(1'b1));
            check("crit_vld", 256'(cache_crit_vld_o), 256'(c == crit_c));
            if (c == crit_c) check("crit_dat", 256'(cache_crit_dat_o), 256'(exp_crit));
            check("ack", 256'(cache_ack_o), 256'(c == ack_c));
            if (c < ack_c) begin
                check("mem_req", 256'(mem_req_o), 256'(1'b1));
                check("sb_nonempty", 256'(exp_q.size() != 0), 256'(1'b1));
                if (exp_q.size() != 0) begin
                    t = exp_q[0];
                    check("mem_we", 256'(mem_we_o), 256'(t.we));
                    check("mem_adr", 256'(mem_adr_o), 256'(t.adr));
                    if (t.we) check("mem_dat", 256'(mem_dat_o), 256'(t.dat));
                    if (mem_ack_i) begin
                        void'(exp_q.pop_front());
                        done++;
                    end
                end
            end else begin
                check("mem_req_end", 256'(mem_req_o), 256'(1'b0));
                check("line", 256'(cache_line_o), 256'(mk_line(rd_base)));
                check("sb_empty", 256'(exp_q.size()), 256'(0));
            end
        end
        cache_req_i = 1'b0;
    endtask

    initial begin
        logic [127:0] old_line;
        rst          = 1'b0;
        cache_req_i  = 1'b0;
        cache_adr_i  = '0;
        victim_vld_i = 1'b0;
        victim_adr_i = '0;
        victim_dat_i = '0;
        mem_ack_i    = 1'b0;
        rd_base      = '0;

        // 1. Reset with random inputs, then idle.
        for (int i = 0; i < 5; i++) begin
            cache_req_i  = 1'($urandom);
            cache_adr_i  = $urandom;
            victim_vld_i = 1'($urandom);
            victim_adr_i = $urandom;
            victim_dat_i = {$urandom, $urandom, $urandom, $urandom};
            mem_ack_i    = 1'($urandom);
            rd_base      = $urandom;
            tick();
            check("reset_outs", all_outs(), 256'd0);
        end
        cache_req_i = 1'b0;
        mem_ack_i   = 1'b1;
        rst         = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", 256'(cache_busy_o), 256'(1'b0));
            check("idle_req", 256'(mem_req_o), 256'(1'b0));
        end

        // 2. Clean miss, critical word 3.
        rd_base = 32'hD0;
        do_miss(32'h00CC3B4C, 1'b0, 32'h0, 128'h0, -1, 0);
        tick();
        check("post_busy", 256'(cache_busy_o), 256'(1'b0));

        // 3. Dirty miss with writeback.
        rd_base = 32'hE0;
        do_miss(32'h00CE0343, 1'b1, 32'h00CC3340,
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, -1, 0);
        tick();

        // 4. Three-cycle stall on the second read.
        rd_base = 32'h40;
        do_miss(32'h00001238, 1'b0, 32'h0, 128'h0, 1, 3);
        tick();

        // 5. Asynchronous reset after two read acks.
        rd_base     = 32'h70;
        cache_req_i = 1'b1;
        cache_adr_i = 32'h00000024;
        mem_ack_i   = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2 rst = 1'b0;
        #1 check("async_reset", all_outs(), 256'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_hold", all_outs(), 256'd0);
        end
        rst         = 1'b1;
        cache_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("no_ack_after_abort", 256'(cache_ack_o), 256'(1'b0));
        end
        rd_base = 32'h80;
        do_miss(32'h00000024, 1'b0, 32'h0, 128'h0, -1, 0);
        tick();

        // 6. Back-to-back: new request the cycle after ack, crit = 2.
        rd_base = 32'h50;
        do_miss(32'h00001234, 1'b0, 32'h0, 128'h0, -1, 0);
        old_line = mk_line(32'h50);
        tick();
        check("b2b_idle", 256'(cache_busy_o), 256'(1'b0));
        check("b2b_line_hold", 256'(cache_line_o), 256'(old_line));
        rd_base = 32'h60;
        do_miss(32'h00005678, 1'b0, 32'h0, 128'h0, -1, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/line_refill_ctrl.md
# line_refill_ctrl

Memory-side refill controller sitting directly downstream of the 4-way cache (`cache4way`). It accepts one line-miss request at a time, optionally writes back a dirty victim line, then fetches the missing 4-word line from word-wide main memory in critical-word-first wrap order. It returns the critical word early and the full assembled line when complete.

## Interface
Parameters:
- ADR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory word width
- WORDS_PER_LINE, 4, words per cache line (fixed at 4; the offset field is bits 3:2)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cache_req_i  input  1  miss request; the cache holds it high until cache_ack_o
- cache_adr_i  input  ADR_WIDTH  miss byte address; bits 3:2 give the critical word
- victim_vld_i  input  1  dirty victim present; sampled with cache_req_i
- victim_adr_i  input  ADR_WIDTH  victim line address; bits 3:0 are ignored
- victim_dat_i  input  4*DATA_WIDTH  victim line; word0 is in bits [31:0]
- cache_busy_o  output  1  high whenever not IDLE
- cache_crit_vld_o  output  1  one-cycle pulse; critical word valid
- cache_crit_dat_o  output  DATA_WIDTH  critical word
- cache_ack_o  output  1  one-cycle pulse; line complete
- cache_line_o  output  4*DATA_WIDTH  assembled line; held until the next accepted request
- mem_req_o  output  1  memory request
- mem_we_o  output  1  1 = write, 0 = read
- mem_adr_o  output  ADR_WIDTH  word-aligned byte address; bits 1:0 = 00
- mem_dat_o  output  DATA_WIDTH  write data
- mem_ack_i  input  1  transfer done in the cycle it is sampled high
- mem_dat_i  input  DATA_WIDTH  read data, valid with mem_ack_i

## Operation
- FSM states: IDLE, WB, RD, RESP.
- IDLE:
  - On cache_req_i=1, latch the line address ({cache_adr_i[31:4]}), crit = cache_adr_i[3:2], victim_vld_i, victim_adr_i[31:4] and victim_dat_i.
  - Clear the word counter.
  - Go to WB if a victim is present, else RD.
- WB:
  - Issue 4 writes in order: word 0, 1, 2, 3.
  - mem_adr_o = {victim_line, k, 2'b00}; mem_dat_o = victim word k.
  - After the 4th ack, go to RD.
  - Writeback always precedes the refill read.
- RD:
  - Issue 4 reads with word index (crit + k) mod 4, k = 0..3. The index wraps 3 to 0.
  - Each ack stores mem_dat_i into line slot (crit + k) mod 4.
  - The first read ack triggers cache_crit_vld_o next cycle.
  - After the 4th ack, go to RESP.
- RESP: assert cache_ack_o for one cycle, then return to IDLE.
- Handshake with memory:
  - mem_req_o, mem_we_o, mem_adr_o and mem_dat_o stay stable until mem_ack_i is sampled high.
  - mem_req_o may stay high across consecutive words; the address advances on the cycle after an ack.
- mem_ack_i outside WB/RD is ignored.
- cache_req_i outside IDLE is ignored. Dropping it mid-operation does not abort the operation.
- A request is accepted in the same cycle the controller re-enters IDLE only if cache_req_i is sampled there. The cache must drop cache_req_i the cycle after cache_ack_o.
- Reset (rst=0, any time):
  - State goes to IDLE and counters clear.
  - All outputs go to 0, including cache_line_o and mem_adr_o.
  - Takes effect asynchronously. No ack is produced for an aborted refill.

## Timing
- Clean miss, mem_ack_i tied high:
  - Request sampled at edge 0.
  - mem_req_o high in cycles 1–4.
  - cache_crit_vld_o in cycle 2.
  - cache_ack_o in cycle 5.
  - cache_busy_o high in cycles 1–5.
- Dirty miss: WB occupies cycles 1–4, RD cycles 5–8, crit pulse cycle 6, ack cycle 9.
- Each memory stall cycle (mem_ack_i=0 while mem_req_o=1) adds exactly one cycle.
- mem_req_o is never 0 between words of the same phase when mem_ack_i is continuously 1.
- All outputs are registered.

## Structure
- Shared package `cache_pkg` holds:
  - ADR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, LINE_WIDTH (= 4*DATA_WIDTH), OFFSET_LSB = 2, LINE_LSB = 4
  - the FSM state enum
  - These are also used by cache4way.
- One sub-module: `line_buffer`. It holds the 4×DATA_WIDTH assembly register with indexed write, a 2-bit wrap counter and the crit offset, and generates the slot index (crit + k) mod 4.

## Test plan
1. Reset: hold rst=0 with random inputs. All outputs must be 0. Release, then hold cache_req_i=0 for 10 cycles; state stays IDLE and mem_req_o=0.
2. Clean miss, cache_adr_i=0x00CC3B4C, mem_ack_i=1, mem_dat_i=0xD0+word index:
   - mem_adr_o sequence is 0x00CC3B4C, 0x00CC3B40, 0x00CC3B44, 0x00CC3B48.
   - crit_dat=0xD3 in cycle 2.
   - cache_line_o={D3,D2,D1,D0} with ack in cycle 5.
3. Dirty miss, victim_adr_i=0x00CC3340, victim words A0..A3, cache_adr_i=0x00CE0343:
   - Four writes to 0x00CC3340–0x00CC334C with data A0..A3 and mem_we_o=1.
   - Then four reads starting at 0x00CE0340.
   - Ack in cycle 9.
4. Memory stall: drop mem_ack_i for 3 cycles on the second read. Address and mem_req_o must hold stable; ack arrives 3 cycles later.
5. Reset mid-refill after 2 read acks: outputs clear immediately, no cache_ack_o. A new request afterwards completes normally.
6. Back-to-back: issue a second request the cycle after ack, with new crit=2. Line register holds until acceptance, then the new refill starts at word 2.
